// File: rtl/fifo_address_sync_level.sv
// fifo_address_sync_level: single-clock FIFO address, fill-level and flag generator for an external dual-port RAM.
// Optional peak-level watermark (peak_clear/peak_level) when FIFO_ADDRESS_PEAK_LEVEL_EN is defined.
module fifo_address_sync_level #(
    parameter int C_ADDRESS_WIDTH       = 4,
    parameter int C_ALMOST_FULL_THRESH  = 12,
    parameter int C_ALMOST_EMPTY_THRESH = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    output logic                       s_axis_empty,
    output logic [C_ADDRESS_WIDTH-1:0] s_axis_waddr,
    output logic [C_ADDRESS_WIDTH:0]   s_axis_room,
    input  logic                       m_axis_ready,
    output logic                       m_axis_valid,
    output logic [C_ADDRESS_WIDTH-1:0] m_axis_raddr_next,
    output logic [C_ADDRESS_WIDTH:0]   m_axis_level,
    output logic                       almost_full,
    output logic                       almost_empty
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
    ,
    input  logic                       peak_clear,
    output logic [C_ADDRESS_WIDTH:0]   peak_level
`endif
);
    localparam int AW = C_ADDRESS_WIDTH;
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
    localparam logic [AW:0] AF = (AW+1)'(C_ALMOST_FULL_THRESH);
    localparam logic [AW:0] AE = (AW+1)'(C_ALMOST_EMPTY_THRESH);
    logic [AW:0] wptr, rptr, rptr_next, level, level_next;
    logic wr, rd;
    always_comb begin
        wr = s_axis_valid & s_axis_ready;
        rd = m_axis_valid & m_axis_ready;
        rptr_next = rptr + {{AW{1'b0}}, rd};
        level_next = level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
    assign s_axis_waddr = wptr[AW-1:0];
    assign m_axis_raddr_next = rptr_next[AW-1:0];
    assign m_axis_level = level;
    // Every flag is registered from level_next so all of them switch on the same edge as level.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            s_axis_ready <= 1'b1;
            s_axis_empty <= 1'b1;
            m_axis_valid <= 1'b0;
            almost_full <= 1'b0;
            almost_empty <= 1'b1;
            s_axis_room <= DEPTH;
        end else begin
            wptr <= wptr + {{AW{1'b0}}, wr};
            rptr <= rptr_next;
            level <= level_next;
            s_axis_ready <= level_next != DEPTH;
            s_axis_empty <= level_next == '0;
            m_axis_valid <= level_next != '0;
            almost_full <= level_next >= AF;
            almost_empty <= level_next <= AE;
            s_axis_room <= DEPTH - level_next;
        end
    end
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) peak_level <= '0;
        else peak_level <= (peak_clear || level_next > peak_level) ? level_next : peak_level;
    end
`endif
endmodule

// File: tb/tb_fifo_address_sync_level.sv
// tb_fifo_address_sync_level: directed bench with a write-first RAM model and a data-order scoreboard.
module tb_fifo_address_sync_level;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 1;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic s_axis_valid = 1'b0;
    logic m_axis_ready = 1'b0;
    logic s_axis_ready, s_axis_empty, m_axis_valid, almost_full, almost_empty;
    logic [AW-1:0] s_axis_waddr, m_axis_raddr_next;
    logic [AW:0] s_axis_room, m_axis_level;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic [7:0] mem [DEPTH];
    logic [7:0] q [$];
    int tests = 0;
    int fails = 0;
    int lvl = 0;
    int wp = 0;
    int rp = 0;
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
    logic peak_clear = 1'b0;
    logic [AW:0] peak_level;
    int pk = 0;
`endif

    fifo_address_sync_level #(
        .C_ADDRESS_WIDTH(AW),
        .C_ALMOST_FULL_THRESH(AF),
        .C_ALMOST_EMPTY_THRESH(AE)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_empty(s_axis_empty),
        .s_axis_waddr(s_axis_waddr),
        .s_axis_room(s_axis_room),
        .m_axis_ready(m_axis_ready),
        .m_axis_valid(m_axis_valid),
        .m_axis_raddr_next(m_axis_raddr_next),
        .m_axis_level(m_axis_level),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
        ,
        .peak_clear(peak_clear),
        .peak_level(peak_level)
`endif
    );

    always #5 aclk = ~aclk;

    // Write-first registered-read RAM, as the generator expects downstream.
    always_ff @(posedge aclk) begin
        if (s_axis_valid && s_axis_ready) mem[s_axis_waddr] <= wdata;
        rdata <= (s_axis_valid && s_axis_ready && s_axis_waddr == m_axis_raddr_next) ? wdata : mem[m_axis_raddr_next];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("level", 32'(m_axis_level), 32'(lvl));
        chk("room", 32'(s_axis_room), 32'(DEPTH - lvl));
        chk("ready", 32'(s_axis_ready), 32'(lvl != DEPTH));
        chk("empty", 32'(s_axis_empty), 32'(lvl == 0));
        chk("valid", 32'(m_axis_valid), 32'(lvl != 0));
        chk("almost_full", 32'(almost_full), 32'(lvl >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(lvl <= AE));
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
        chk("peak_level", 32'(peak_level), 32'(pk));
`endif
    endtask

    // One clock: drive after a falling edge, check before the rising edge, update the model.
    task automatic cycle(input logic v, input logic r);
        logic w, rd;
        logic [7:0] exp_d;
        s_axis_valid = v;
        m_axis_ready = r;
        #1;
        w = v && lvl != DEPTH;
        rd = r && lvl != 0;
        check_out();
        chk("waddr", 32'(s_axis_waddr), 32'(wp));
        chk("raddr_next", 32'(m_axis_raddr_next), 32'((rp + int'(rd)) % DEPTH));
        if (rd) begin
            exp_d = q.pop_front();
            chk("rdata", 32'(rdata), 32'(exp_d));
            rp = (rp + 1) % DEPTH;
        end
        if (w) begin
            q.push_back(wdata);
            wp = (wp + 1) % DEPTH;
        end
        lvl = lvl + int'(w) - int'(rd);
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
        pk = (peak_clear || lvl > pk) ? lvl : pk;
`endif
        @(negedge aclk);
        wdata = wdata + 8'd1;
    endtask

    task automatic model_reset();
        lvl = 0;
        wp = 0;
        rp = 0;
        q.delete();
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
        pk = 0;
`endif
    endtask

    initial begin
        repeat (2) @(negedge aclk);
        #1;
        check_out();
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) cycle(1'b0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        #1;
        chk("full_waddr_hold", 32'(s_axis_waddr), 32'd0);
        chk("full_level", 32'(m_axis_level), 32'(DEPTH));
        cycle(1'b1, 1'b1);
        #1;
        chk("ready_after_read", 32'(s_axis_ready), 32'd1);
        chk("level_after_read", 32'(m_axis_level), 32'(DEPTH - 1));
        cycle(1'b1, 1'b0);
        #1;
        chk("refill_level", 32'(m_axis_level), 32'(DEPTH));
        repeat (5) cycle(1'b0, 1'b1);
        repeat (40) cycle(1'b1, 1'b1);
        #1;
        chk("stream_level", 32'(m_axis_level), 32'd3);
        repeat (2) cycle(1'b1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        model_reset();
        check_out();
        chk("reset_raddr_next", 32'(m_axis_raddr_next), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
`ifdef FIFO_ADDRESS_PEAK_LEVEL_EN
        repeat (7) cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b1);
        #1;
        chk("peak_hold", 32'(peak_level), 32'd7);
        peak_clear = 1'b1;
        cycle(1'b0, 1'b0);
        peak_clear = 1'b0;
        #1;
        chk("peak_cleared", 32'(peak_level), 32'd2);
        cycle(1'b1, 1'b0);
        #1;
        chk("peak_rise", 32'(peak_level), 32'd3);
        cycle(1'b0, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
